paper_cpu_ctrl: RTL and testbench

Control unit for the paper processor: sequences the 2-bit instruction ROM by driving its address and executing the three-instruction ISA (INC, JNO, HLT) against an internal accumulator. It sits between the ROM (combinational `addr -> data`) and the top level, which starts programs and observes results. One instruction executes at a time; no pipelining.

---
 rtl/paper_pkg.sv | 21 ++
 rtl/sat_counter.sv | 34 +++
 rtl/paper_cpu_ctrl.sv | 146 ++++++++++++++
 tb/tb_paper_cpu_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/paper_pkg.sv
// paper_pkg: shared definitions for the paper processor control unit.
//   ADDR_W      - ROM address width (the ROM holds four 2-bit words)
//   OP_*        - opcode encodings; 2'b11 is the illegal opcode
//   state_t     - control FSM states
package paper_pkg;

  localparam int ADDR_W = 2;

  localparam logic [1:0] OP_INC = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_HLT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_OPERAND,
    ST_HALT
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter for the retired-instruction count.
// Ports:
//   clk    in     clock, rising edge
//   rst_n  in     asynchronous active-low reset
//   clr    in     synchronous clear (wins over inc)
//   inc    in     count one event
//   count  out    CNT_W-bit count, holds at all-ones
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/paper_cpu_ctrl.sv
// paper_cpu_ctrl: control unit of the paper processor. Drives the 2-bit
// ROM address, executes INC / JNO / HLT against an internal accumulator
// one instruction at a time.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   starts/restarts the program when idle or halted
//   rom_addr     out  ROM address (the PC register)
//   rom_data     in   ROM word at rom_addr, combinational
//   acc          out  accumulator
//   ov           out  carry out of the most recent INC
//   busy         out  high while an instruction is in flight
//   halted       out  high in HALT
//   illegal      out  opcode 11 was decoded since the last start
//   instr_count  out  retired instructions since the last start, saturating
module paper_cpu_ctrl
  import paper_pkg::*;
#(
  parameter int ACC_W = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [1:0]        rom_data,
  output logic [ACC_W-1:0]  acc,
  output logic              ov,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_reg,   state_next;
  logic [ADDR_W-1:0] pc_reg,      pc_next;
  logic [1:0]        ir_reg,      ir_next;
  logic [ACC_W-1:0]  acc_reg,     acc_next;
  logic              ov_reg,      ov_next;
  logic              illegal_reg, illegal_next;
  logic              count_clr;
  logic              count_inc;
  logic [ACC_W:0]    acc_sum;

  // One extra bit captures the carry out of the all-ones -> zero wrap.
  assign acc_sum = {1'b0, acc_reg} + {{ACC_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      ir_reg      <= '0;
      acc_reg     <= '0;
      ov_reg      <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      acc_reg     <= acc_next;
      ov_reg      <= ov_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    acc_next     = acc_reg;
    ov_next      = ov_reg;
    illegal_next = illegal_reg;
    count_clr    = 1'b0;
    count_inc    = 1'b0;

    case (state_reg)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_next      = '0;
          acc_next     = '0;
          ov_next      = 1'b0;
          illegal_next = 1'b0;
          count_clr    = 1'b1;
          state_next   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_next    = rom_data;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (ir_reg)
          OP_INC: begin
            {ov_next, acc_next} = acc_sum;
            pc_next    = pc_reg + PC_ONE;
            count_inc  = 1'b1;
            state_next = ST_FETCH;
          end
          OP_JNO: begin
            // Step onto the operand word; it is read in OPERAND.
            pc_next    = pc_reg + PC_ONE;
            state_next = ST_OPERAND;
          end
          OP_HLT: begin
            count_inc  = 1'b1;
            state_next = ST_HALT;
          end
          default: begin
            illegal_next = 1'b1;
            state_next   = ST_HALT;
          end
        endcase
      end
      ST_OPERAND: begin
        // pc_reg points at the operand; "not taken" skips past it.
        pc_next    = ov_reg ? (pc_reg + PC_ONE) : rom_data;
        count_inc  = 1'b1;
        state_next = ST_FETCH;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (count_clr),
    .inc   (count_inc),
    .count (instr_count)
  );

  assign rom_addr = pc_reg;
  assign acc      = acc_reg;
  assign ov       = ov_reg;
  assign illegal  = illegal_reg;
  assign busy     = (state_reg == ST_FETCH) || (state_reg == ST_EXEC) ||
                    (state_reg == ST_OPERAND);
  assign halted   = (state_reg == ST_HALT);

endmodule

// File: tb/tb_paper_cpu_ctrl.sv
// tb_paper_cpu_ctrl: self-checking bench for paper_cpu_ctrl. A ROM array
// feeds rom_data; an instruction-level reference model predicts the
// architectural state and the cycle at which each instruction retires.
module tb_paper_cpu_ctrl;

  localparam int ACC_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       rom_addr;
  logic [1:0]       rom_data;
  logic [ACC_W-1:0] acc;
  logic             ov;
  logic             busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  logic [1:0] rom [4];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  paper_cpu_ctrl #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .acc         (acc),
    .ov          (ov),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state only.
  int m_pc, m_acc, m_ov, m_cnt, m_halt, m_ill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".acc"},     32'(acc),         32'(m_acc));
    check({tag, ".ov"},      32'(ov),          32'(m_ov));
    check({tag, ".pc"},      32'(rom_addr),    32'(m_pc));
    check({tag, ".count"},   32'(instr_count), 32'(m_cnt));
    check({tag, ".halted"},  32'(halted),      32'(m_halt));
    check({tag, ".illegal"}, 32'(illegal),     32'(m_ill));
    check({tag, ".busy"},    32'(busy),        32'(m_halt == 0));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".acc"},     32'(acc),         32'd0);
    check({tag, ".ov"},      32'(ov),          32'd0);
    check({tag, ".pc"},      32'(rom_addr),    32'd0);
    check({tag, ".count"},   32'(instr_count), 32'd0);
    check({tag, ".halted"},  32'(halted),      32'd0);
    check({tag, ".illegal"}, 32'(illegal),     32'd0);
    check({tag, ".busy"},    32'(busy),        32'd0);
  endtask

  task automatic bump_count();
    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endtask

  // Advance n clock edges; optionally toggle start randomly, which the
  // DUT must ignore while busy. Returns at posedge + 1.
  task automatic step_cycles(input int n, input bit noise);
    repeat (n) begin
      @(negedge clk);
      start = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(posedge clk);
    end
    #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start the loaded program (DUT must be in IDLE or HALT) and follow it
  // instruction by instruction for at most max_instr instructions.
  task automatic run_program(input string name, input int max_instr, input bit noise);
    int cycles;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    m_pc = 0; m_acc = 0; m_ov = 0; m_cnt = 0; m_halt = 0; m_ill = 0;
    cycles = 0;
    check_state({name, ".start"});
    for (int i = 0; i < max_instr && m_halt == 0; i++) begin
      int op;
      int cyc;
      op = int'(rom[m_pc]);
      case (op)
        0: begin
          cyc   = 2;
          m_acc = m_acc + 1;
          m_ov  = (m_acc == (1 << ACC_W)) ? 1 : 0;
          m_acc = m_acc % (1 << ACC_W);
          m_pc  = (m_pc + 1) % 4;
          bump_count();
        end
        1: begin
          cyc = 3;
          if (m_ov == 0) m_pc = int'(rom[(m_pc + 1) % 4]);
          else           m_pc = (m_pc + 2) % 4;
          bump_count();
        end
        2: begin
          cyc    = 2;
          m_halt = 1;
          bump_count();
        end
        default: begin
          cyc    = 2;
          m_ill  = 1;
          m_halt = 1;
        end
      endcase
      step_cycles(cyc, noise);
      cycles += cyc;
      check_state(name);
    end
    $display("[TB] %s: %0d cycles acc=%0d ov=%0d count=%0d halted=%0d illegal=%0d",
             name, cycles, acc, ov, instr_count, halted, illegal);
  endtask

  initial begin
    rom[0] = 2'b00; rom[1] = 2'b00; rom[2] = 2'b00; rom[3] = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("idle_wait");

    // Count-up loop: 16 INC/JNO pairs then HLT, 82 cycles, count 33.
    rom[0] = 2'b00; rom[1] = 2'b01; rom[2] = 2'b00; rom[3] = 2'b10;
    run_program("inc_jno_loop", 100, 1'b1);

    // Restart straight from HALT with a new program.
    rom[0] = 2'b00; rom[1] = 2'b00; rom[2] = 2'b10; rom[3] = 2'b11;
    run_program("restart_from_halt", 10, 1'b0);

    // Illegal opcode, then a restart must clear the flag.
    rom[0] = 2'b11; rom[1] = 2'b00; rom[2] = 2'b00; rom[3] = 2'b00;
    run_program("illegal_op", 10, 1'b1);
    rom[0] = 2'b10;
    run_program("clear_illegal", 10, 1'b0);

    // Reset asserted mid-EXEC takes effect without a clock edge.
    apply_reset();
    rom[0] = 2'b00; rom[1] = 2'b00; rom[2] = 2'b00; rom[3] = 2'b00;
    run_program("pre_abort", 3, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_reset("abort_idle");

    // Free-running loop with wrap through address 3 -> 0; count saturates.
    rom[0] = 2'b00; rom[1] = 2'b00; rom[2] = 2'b00; rom[3] = 2'b01;
    run_program("saturate_loop", 300, 1'b1);
    apply_reset();

    // Random programs, each from a clean reset.
    for (int t = 0; t < 15; t++) begin
      for (int a = 0; a < 4; a++) rom[a] = 2'($urandom_range(0, 3));
      run_program($sformatf("random_%0d", t), 40, 1'($urandom_range(0, 1)));
      apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
